// File: rtl/dm_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dm_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    ACK  = 2'd3
  } state_t;

  localparam logic [3:0] BE_FULL = 4'hF;
  localparam logic       P_CPU   = 1'b0;
  localparam logic       P_DBG   = 1'b1;

  // With both ports requesting under round-robin, the port that did not win last goes next.
  function automatic logic pick_winner(input logic i_req0, input logic i_req1,
                                       input logic i_last, input logic i_rr_en);
    if (i_rr_en && i_req0 && i_req1) return ~i_last;
    return i_req0 ? P_CPU : P_DBG;
  endfunction

endpackage

// File: rtl/dm_be_merge.sv
// Byte-lane merge: lanes with be[i] set take the new word, the others keep the old word.
module dm_be_merge (
  input  logic [31:0] i_old,
  input  logic [31:0] i_new,
  input  logic [3:0]  i_be,
  output logic [31:0] o_merged
);

  always_comb begin
    o_merged = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      o_merged[8*i +: 8] = i_be[i] ? i_new[8*i +: 8] : i_old[8*i +: 8];
    end
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Two-port arbiter in front of a single-port word memory; partial stores become read-modify-write.
module dm_port_arbiter
  import dm_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter bit          RR_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  input  logic [3:0]        be0,
  input  logic [3:0]        be1,
  output logic              ack0,
  output logic              ack1,
  output logic [31:0]       rdata0,
  output logic [31:0]       rdata1,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata
);

  state_t              r_state;
  logic                r_last;
  logic                r_win;
  logic                r_we;
  logic [31:0]         r_wdata;
  logic [3:0]          r_be;
  logic [31:0]         r_hold;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_mem_we;
  logic                r_ack0;
  logic                r_ack1;

  logic                w_any;
  logic                w_win;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [31:0]         w_sel_wdata;
  logic [3:0]          w_sel_be;
  logic [31:0]         w_merged;

  always_comb begin
    w_any       = req0 | req1;
    w_win       = pick_winner(req0, req1, r_last, RR_EN);
    w_sel_we    = (w_win == P_CPU) ? we0    : we1;
    w_sel_addr  = (w_win == P_CPU) ? addr0  : addr1;
    w_sel_wdata = (w_win == P_CPU) ? wdata0 : wdata1;
    w_sel_be    = (w_win == P_CPU) ? be0    : be1;
  end

  // A full store has be=BE_FULL, so the merge yields the latched wdata whatever the hold register holds.
  dm_be_merge u_merge (
    .i_old    (r_hold),
    .i_new    (r_wdata),
    .i_be     (r_be),
    .o_merged (w_merged)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_last     <= P_DBG;
      r_win      <= P_CPU;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_hold     <= '0;
      r_mem_addr <= '0;
      r_mem_we   <= 1'b0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_win   <= w_win;
            r_we    <= w_sel_we;
            r_wdata <= w_sel_wdata;
            r_be    <= w_sel_be;
            if (!w_sel_we || (w_sel_be != BE_FULL && w_sel_be != '0)) begin
              r_state    <= RD;
              r_mem_addr <= w_sel_addr;
            end else if (w_sel_be == BE_FULL) begin
              r_state    <= WR;
              r_mem_addr <= w_sel_addr;
              r_mem_we   <= 1'b1;
            end else begin
              r_state <= ACK;
              r_ack0  <= (w_win == P_CPU);
              r_ack1  <= (w_win == P_DBG);
            end
          end
        end
        RD: begin
          r_hold <= mem_rdata;
          if (!r_we) begin
            r_state    <= ACK;
            r_mem_addr <= '0;
            r_ack0     <= (r_win == P_CPU);
            r_ack1     <= (r_win == P_DBG);
          end else begin
            r_state  <= WR;
            r_mem_we <= 1'b1;
          end
        end
        WR: begin
          r_state    <= ACK;
          r_mem_we   <= 1'b0;
          r_mem_addr <= '0;
          r_ack0     <= (r_win == P_CPU);
          r_ack1     <= (r_win == P_DBG);
        end
        ACK: begin
          r_state <= IDLE;
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_last  <= r_win;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign rdata0    = (r_ack0 && !r_we) ? r_hold : '0;
  assign rdata1    = (r_ack1 && !r_we) ? r_hold : '0;
  assign busy      = (r_state != IDLE);
  assign mem_addr  = r_mem_addr;
  assign mem_we    = r_mem_we;
  assign mem_wdata = (r_state == WR) ? w_merged : '0;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Scoreboard bench: two arbiters (round-robin and fixed priority), each with its own word memory.
module tb_dm_port_arbiter;

  typedef struct {
    int          inst;
    int          port;
    logic [31:0] rdata;
  } ack_t;

  typedef struct {
    int          inst;
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req   [2][2];
  logic        we    [2][2];
  logic [31:0] addr  [2][2];
  logic [31:0] wdata [2][2];
  logic [3:0]  be    [2][2];
  logic        ack   [2][2];
  logic [31:0] rdata [2][2];
  logic        busy      [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic        mem_we    [2];
  logic [31:0] mem [2][256];

  ack_t ack_q[$];
  wr_t  wr_q[$];
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  dm_port_arbiter #(.ADDR_W(32), .RR_EN(1'b1)) u_rr (
    .clk(clk), .reset(reset),
    .req0(req[0][0]), .req1(req[0][1]), .we0(we[0][0]), .we1(we[0][1]),
    .addr0(addr[0][0]), .addr1(addr[0][1]), .wdata0(wdata[0][0]), .wdata1(wdata[0][1]),
    .be0(be[0][0]), .be1(be[0][1]), .ack0(ack[0][0]), .ack1(ack[0][1]),
    .rdata0(rdata[0][0]), .rdata1(rdata[0][1]), .busy(busy[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_we(mem_we[0]),
    .mem_rdata(mem_rdata[0])
  );

  dm_port_arbiter #(.ADDR_W(32), .RR_EN(1'b0)) u_fp (
    .clk(clk), .reset(reset),
    .req0(req[1][0]), .req1(req[1][1]), .we0(we[1][0]), .we1(we[1][1]),
    .addr0(addr[1][0]), .addr1(addr[1][1]), .wdata0(wdata[1][0]), .wdata1(wdata[1][1]),
    .be0(be[1][0]), .be1(be[1][1]), .ack0(ack[1][0]), .ack1(ack[1][1]),
    .rdata0(rdata[1][0]), .rdata1(rdata[1][1]), .busy(busy[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_we(mem_we[1]),
    .mem_rdata(mem_rdata[1])
  );

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_we[i]) mem[i][mem_addr[i][9:2]] = mem_wdata[i];
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) mem_rdata[i] = mem[i][mem_addr[i][9:2]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every ack and every write strobe must match the next queued expectation.
  always @(negedge clk) begin
    ack_t ea;
    wr_t  ew;
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        for (int p = 0; p < 2; p++) begin
          if (ack[i][p]) begin
            if (ack_q.size() == 0) begin
              checks++;
              $display("FAIL unexpected_ack: inst %0d port %0d got ack expected none", i, p);
            end else begin
              ea = ack_q.pop_front();
              check("ack_inst", 32'(i), 32'(ea.inst));
              check("ack_port", 32'(p), 32'(ea.port));
              check("ack_rdata", rdata[i][p], ea.rdata);
              check("idle_rdata", rdata[i][1-p], 32'h0);
            end
          end
        end
        if (mem_we[i]) begin
          if (wr_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_write: inst %0d got mem_we addr %h expected none", i, mem_addr[i]);
          end else begin
            ew = wr_q.pop_front();
            check("wr_inst", 32'(i), 32'(ew.inst));
            check("wr_addr", mem_addr[i], ew.a);
            check("wr_data", mem_wdata[i], ew.d);
          end
        end
      end
    end
  end

  task automatic do_req(input int i, input int p, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b, input int exp_lat,
                        input bit early);
    int cnt;
    bit got;
    @(negedge clk);
    req[i][p] = 1'b1; we[i][p] = w; addr[i][p] = a; wdata[i][p] = d; be[i][p] = b;
    cnt = 0;
    got = 1'b0;
    while (!got && cnt < 60) begin
      @(negedge clk);
      cnt++;
      if (early && cnt == 1) req[i][p] = 1'b0;
      got = ack[i][p];
    end
    req[i][p] = 1'b0; we[i][p] = 1'b0; addr[i][p] = '0; wdata[i][p] = '0; be[i][p] = '0;
    if (!got) begin
      checks++;
      $display("FAIL ack_timeout: inst %0d port %0d got no ack expected ack within 60 cycles", i, p);
    end else if (exp_lat >= 0) begin
      check("latency", 32'(cnt), 32'(exp_lat));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    int cnt;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++) begin
        req[i][p] = 1'b0; we[i][p] = 1'b0; addr[i][p] = '0; wdata[i][p] = '0; be[i][p] = '0;
      end
      for (int k = 0; k < 256; k++) mem[i][k] = '0;
      for (int k = 0; k < 3; k++) begin
        mem[i][64 + k]  = 32'hA000_0000 + 32'(k);
        mem[i][128 + k] = 32'hB000_0000 + 32'(k);
      end
    end
    mem[0][4]  = 32'hDEADBEEF;
    mem[0][12] = 32'hAABBCCDD;
    mem[0][16] = 32'h11223344;
    mem[0][17] = 32'h55667788;

    repeat (2) @(negedge clk);
    check("rst_ack0", 32'(ack[0][0]), 32'h0);
    check("rst_ack1", 32'(ack[0][1]), 32'h0);
    check("rst_busy", 32'(busy[0]), 32'h0);
    check("rst_mem_we", 32'(mem_we[0]), 32'h0);
    check("rst_mem_addr", mem_addr[0], 32'h0);
    check("rst_mem_wdata", mem_wdata[0], 32'h0);
    check("rst_rdata0", rdata[0][0], 32'h0);
    reset = 1'b0;

    // Load, full store, partial store, same-word read-after-write.
    ack_q.push_back('{0, 0, 32'hDEADBEEF});
    do_req(0, 0, 1'b0, 32'h10, 32'h0, 4'h0, 2, 1'b0);
    wr_q.push_back('{0, 32'h20, 32'h12345678});
    ack_q.push_back('{0, 1, 32'h0});
    do_req(0, 1, 1'b1, 32'h20, 32'h12345678, 4'hF, 2, 1'b0);
    wr_q.push_back('{0, 32'h30, 32'hAABB11DD});
    ack_q.push_back('{0, 0, 32'h0});
    do_req(0, 0, 1'b1, 32'h30, 32'h00001100, 4'b0010, 3, 1'b0);
    check("mem_0x30", mem[0][12], 32'hAABB11DD);
    ack_q.push_back('{0, 0, 32'h12345678});
    do_req(0, 0, 1'b0, 32'h20, 32'h0, 4'h0, 2, 1'b0);

    // Store with no enabled lanes, then a load whose req drops early.
    ack_q.push_back('{0, 1, 32'h0});
    do_req(0, 1, 1'b1, 32'h44, 32'hFFFFFFFF, 4'h0, 1, 1'b0);
    check("mem_0x44", mem[0][17], 32'h55667788);
    ack_q.push_back('{0, 0, 32'hDEADBEEF});
    do_req(0, 0, 1'b0, 32'h10, 32'h0, 4'h0, 2, 1'b1);

    // Reset asserted while the partial store is in its write cycle.
    wr_q.push_back('{0, 32'h40, 32'hAA2233BB});
    @(negedge clk);
    req[0][0] = 1'b1; we[0][0] = 1'b1; addr[0][0] = 32'h40; wdata[0][0] = 32'hAA0000BB; be[0][0] = 4'b1001;
    cnt = 0;
    while (!mem_we[0] && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("rmw_reached_wr", 32'(mem_we[0]), 32'h1);
    #1 reset = 1'b1;
    req[0][0] = 1'b0; we[0][0] = 1'b0; addr[0][0] = '0; wdata[0][0] = '0; be[0][0] = '0;
    #1;
    check("midrst_mem_we", 32'(mem_we[0]), 32'h0);
    check("midrst_busy", 32'(busy[0]), 32'h0);
    check("midrst_ack0", 32'(ack[0][0]), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("midrst_mem_0x40", mem[0][16], 32'h11223344);
    ack_q.push_back('{0, 0, 32'h11223344});
    do_req(0, 0, 1'b0, 32'h40, 32'h0, 4'h0, 2, 1'b0);

    // Contention: three loads per port on each arbiter flavour.
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ack_q.push_back('{0, 0, 32'hA000_0000 + 32'(k)});
      ack_q.push_back('{0, 1, 32'hB000_0000 + 32'(k)});
    end
    fork
      begin
        for (int k = 0; k < 3; k++) do_req(0, 0, 1'b0, 32'h100 + 32'(4*k), 32'h0, 4'h0, -1, 1'b0);
      end
      begin
        for (int j = 0; j < 3; j++) do_req(0, 1, 1'b0, 32'h200 + 32'(4*j), 32'h0, 4'h0, -1, 1'b0);
      end
    join
    for (int k = 0; k < 3; k++) ack_q.push_back('{1, 0, 32'hA000_0000 + 32'(k)});
    for (int k = 0; k < 3; k++) ack_q.push_back('{1, 1, 32'hB000_0000 + 32'(k)});
    fork
      begin
        for (int k = 0; k < 3; k++) do_req(1, 0, 1'b0, 32'h100 + 32'(4*k), 32'h0, 4'h0, -1, 1'b0);
      end
      begin
        for (int j = 0; j < 3; j++) do_req(1, 1, 1'b0, 32'h200 + 32'(4*j), 32'h0, 4'h0, -1, 1'b0);
      end
    join

    repeat (3) @(negedge clk);
    check("ack_q_drained", 32'(ack_q.size()), 32'h0);
    check("wr_q_drained", 32'(wr_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
